// File: rtl/vga_pkg.sv
// Purpose: shared constants, FSM encoding and helpers for the tile flip controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control in this package).
package vga_pkg;

  // Tile geometry. The tile spans TILE_X..TILE_X+A_side inclusive, and likewise in Y.
  localparam int A_side  = 128;
  localparam int B_side  = 128;
  localparam int N_TILES = 4;

  // Twelve-bit copies of the tile sides, so bound arithmetic stays at port width.
  localparam logic [11:0] TILE_W = 12'(A_side);
  localparam logic [11:0] TILE_H = 12'(B_side);

  localparam logic [11:0] TILE_X [N_TILES] = '{12'd64, 12'd256, 12'd448, 12'd640};
  localparam logic [11:0] TILE_Y [N_TILES] = '{12'd200, 12'd200, 12'd200, 12'd200};

  // Upper limit on the number of tiles that may be face-up at once.
  localparam logic [2:0] MAX_UP = 3'd2;

  // Click FSM: wait for a press, track the held button, resolve the flip.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_COMMIT = 2'd2
  } flip_state_e;

  // Population count of the face-up mask.
  function automatic logic [2:0] count_up(input logic [3:0] f);
    count_up = 3'(f[0]) + 3'(f[1]) + 3'(f[2]) + 3'(f[3]);
  endfunction

endpackage

// File: rtl/tile_hit.sv
// Purpose: combinational hit test of a position against the four tiles, lowest index wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the result is valid whenever the position inputs are.
module tile_hit
  import vga_pkg::*;
(
  input  logic [11:0] pos_x_i,
  input  logic [11:0] pos_y_i,
  output logic        hit_o,
  output logic [1:0]  idx_o
);

  // Scan from the highest index down, so a lower-index tile overrides on overlap.
  always_comb begin
    hit_o = 1'b0;
    idx_o = 2'd0;
    for (int k = N_TILES - 1; k >= 0; k--) begin
      if ((pos_x_i >= TILE_X[k]) && (pos_x_i <= TILE_X[k] + TILE_W) &&
          (pos_y_i >= TILE_Y[k]) && (pos_y_i <= TILE_Y[k] + TILE_H)) begin
        hit_o = 1'b1;
        idx_o = 2'(k);
      end
    end
  end

endmodule

// File: rtl/tile_flip_ctrl.sv
// Purpose: mouse click-to-flip controller for four tiles, plus per-pixel picture/background select.
// Latency: flip/reject strobe and face_up update 1 cycle after COMMIT; rgb_out 1 cycle after hcount/vcount.
// Backpressure: none; presses that arrive while a click is in flight are dropped, not queued.
module tile_flip_ctrl
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mouse_left,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [11:0] rgb_image,
  input  logic [11:0] rgb_bg,
  output logic [11:0] rgb_out,
  output logic [3:0]  face_up,
  output logic [2:0]  up_count,
  output logic        flip_pulse,
  output logic        reject_pulse
);

  // Registered state.
  flip_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  face_up_q, face_up_d;
  logic [2:0]  up_count_q, up_count_d;
  logic        flip_q, flip_d;
  logic        reject_q, reject_d;
  logic [11:0] rgb_q, rgb_d;
  logic        mouse_q;
  logic        armed_q, armed_d;

  // Hit test results for the cursor and the current pixel.
  logic        cur_hit, pix_hit;
  logic [1:0]  cur_idx, pix_idx;
  logic        press;

  tile_hit u_cursor_hit (
    .pos_x_i (xpos),
    .pos_y_i (ypos),
    .hit_o   (cur_hit),
    .idx_o   (cur_idx)
  );

  tile_hit u_pixel_hit (
    .pos_x_i ({1'b0, hcount}),
    .pos_y_i ({1'b0, vcount}),
    .hit_o   (pix_hit),
    .idx_o   (pix_idx)
  );

  // A button held across reset must be seen released once before any edge counts.
  // armed_q stays low until the first low level after reset, then sticks high.
  assign armed_d = armed_q | ~mouse_left;
  assign press   = mouse_left & ~mouse_q & armed_q;

  // Button history: previous level for edge detection and the post-reset arm flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mouse_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      mouse_q <= mouse_left;
      armed_q <= armed_d;
    end
  end

  // Click FSM next state, latched tile, face-up update and event strobes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    face_up_d = face_up_q;
    flip_d    = 1'b0;
    reject_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A press outside every tile is simply dropped.
        if (press && cur_hit) begin
          idx_d   = cur_idx;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        // The click only counts if the button is released over the same tile.
        if (!mouse_left) begin
          if (cur_hit && (cur_idx == idx_q)) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        // Turning a tile down is always allowed; turning one up is capped at MAX_UP.
        if (face_up_q[idx_q]) begin
          face_up_d[idx_q] = 1'b0;
          flip_d           = 1'b1;
        end else if (up_count_q < MAX_UP) begin
          face_up_d[idx_q] = 1'b1;
          flip_d           = 1'b1;
        end else begin
          reject_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The count tracks the mask it is registered alongside, so both change on the same edge.
  assign up_count_d = count_up(face_up_d);

  // Pixel select uses the face-up mask as registered in this cycle.
  assign rgb_d = (pix_hit && face_up_q[pix_idx]) ? rgb_image : rgb_bg;

  // FSM, tile state and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      face_up_q  <= 4'd0;
      up_count_q <= 3'd0;
      flip_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      face_up_q  <= face_up_d;
      up_count_q <= up_count_d;
      flip_q     <= flip_d;
      reject_q   <= reject_d;
    end
  end

  // Output pixel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 12'd0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_out      = rgb_q;
  assign face_up      = face_up_q;
  assign up_count     = up_count_q;
  assign flip_pulse   = flip_q;
  assign reject_pulse = reject_q;

endmodule

// File: tb/tb_tile_flip_ctrl.sv
// Purpose: self-checking bench for tile_flip_ctrl: click vectors, pixel vectors, corner sequences, random clicks.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_tile_flip_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mouse_left;
  logic [11:0] xpos, ypos;
  logic [10:0] hcount, vcount;
  logic [11:0] rgb_image, rgb_bg;
  logic [11:0] rgb_out;
  logic [3:0]  face_up;
  logic [2:0]  up_count;
  logic        flip_pulse, reject_pulse;

  int checks = 0;
  int errors = 0;
  int nflip_acc = 0;
  int nrej_acc = 0;

  localparam int TX [4] = '{64, 256, 448, 640};
  localparam int TY     = 200;
  localparam int SIDE   = 128;
  localparam int MAXU   = 2;

  tile_flip_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mouse_left   (mouse_left),
    .xpos         (xpos),
    .ypos         (ypos),
    .hcount       (hcount),
    .vcount       (vcount),
    .rgb_image    (rgb_image),
    .rgb_bg       (rgb_bg),
    .rgb_out      (rgb_out),
    .face_up      (face_up),
    .up_count     (up_count),
    .flip_pulse   (flip_pulse),
    .reject_pulse (reject_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] px, py, rx, ry;
    logic [3:0]  fu;
    logic [2:0]  cnt;
    int          fl, rj;
  } click_vec_t;

  typedef struct {
    logic [10:0] h, v;
    logic        img;
  } pix_vec_t;

  click_vec_t cv [5];
  pix_vec_t   pv [7];

  // Reference state for the random phase.
  int m_fu [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; sample outputs 1 time unit after the rising edge and tally strobes.
  task automatic step();
    @(posedge clk);
    #1;
    if (flip_pulse === 1'b1) nflip_acc++;
    if (reject_pulse === 1'b1) nrej_acc++;
    if (flip_pulse === 1'b1 && reject_pulse === 1'b1) begin
      check("pulse_exclusive", 32'd1, 32'd0);
    end
  endtask

  task automatic do_click(input logic [11:0] px, input logic [11:0] py,
                          input logic [11:0] rx, input logic [11:0] ry, input int hold);
    mouse_left = 1'b0;
    step();
    nflip_acc = 0;
    nrej_acc  = 0;
    xpos = px; ypos = py; mouse_left = 1'b1;
    repeat (hold + 1) step();
    xpos = rx; ypos = ry; mouse_left = 1'b0;
    repeat (4) step();
  endtask

  // Which tile a point lies in, by plain inclusive range tests; -1 for none.
  function automatic int tile_of(input int x, input int y);
    for (int k = 0; k < 4; k++) begin
      if (x >= TX[k] && x <= TX[k] + SIDE && y >= TY && y <= TY + SIDE) return k;
    end
    return -1;
  endfunction

  function automatic int rand_x();
    int sel;
    int offs [4];
    offs = '{-1, 0, SIDE, SIDE + 1};
    sel = int'($urandom_range(0, 2));
    if (sel == 0) return int'($urandom_range(0, 900));
    if (sel == 1) return TX[$urandom_range(0, 3)] + offs[$urandom_range(0, 3)];
    return TX[$urandom_range(0, 3)] + int'($urandom_range(0, SIDE));
  endfunction

  function automatic int rand_y();
    int sel;
    int offs [4];
    offs = '{-1, 0, SIDE, SIDE + 1};
    sel = int'($urandom_range(0, 2));
    if (sel == 0) return int'($urandom_range(150, 380));
    if (sel == 1) return TY + offs[$urandom_range(0, 3)];
    return TY + int'($urandom_range(0, SIDE));
  endfunction

  initial begin
    // Click vectors, applied in order from reset.
    cv[0] = '{12'd100, 12'd250, 12'd100, 12'd250, 4'b0001, 3'd1, 1, 0};
    cv[1] = '{12'd100, 12'd250, 12'd300, 12'd250, 4'b0001, 3'd1, 0, 0};
    cv[2] = '{12'd300, 12'd250, 12'd300, 12'd250, 4'b0011, 3'd2, 1, 0};
    cv[3] = '{12'd500, 12'd250, 12'd500, 12'd250, 4'b0011, 3'd2, 0, 1};
    cv[4] = '{12'd100, 12'd250, 12'd100, 12'd250, 4'b0010, 3'd1, 1, 0};
    // Pixel vectors with only tile 1 face-up.
    pv[0] = '{11'd256, 11'd200, 1'b1};
    pv[1] = '{11'd384, 11'd328, 1'b1};
    pv[2] = '{11'd385, 11'd200, 1'b0};
    pv[3] = '{11'd100, 11'd250, 1'b0};
    pv[4] = '{11'd255, 11'd200, 1'b0};
    pv[5] = '{11'd256, 11'd199, 1'b0};
    pv[6] = '{11'd300, 11'd329, 1'b0};

    // Reset state, with non-zero inputs present.
    rst_n = 1'b0; mouse_left = 1'b0; xpos = 12'd100; ypos = 12'd250;
    hcount = 11'd256; vcount = 11'd200; rgb_image = 12'hABC; rgb_bg = 12'h123;
    step(); step();
    check("rst_face_up", face_up, 0);
    check("rst_up_count", up_count, 0);
    check("rst_rgb_out", rgb_out, 0);
    check("rst_flip", flip_pulse, 0);
    check("rst_reject", reject_pulse, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_rgb_bg", rgb_out, 12'h123);

    // Table-driven clicks.
    for (int i = 0; i < 5; i++) begin
      do_click(cv[i].px, cv[i].py, cv[i].rx, cv[i].ry, 2);
      check($sformatf("click%0d_face_up", i), face_up, cv[i].fu);
      check($sformatf("click%0d_up_count", i), up_count, cv[i].cnt);
      check($sformatf("click%0d_flips", i), nflip_acc, cv[i].fl);
      check($sformatf("click%0d_rejects", i), nrej_acc, cv[i].rj);
    end

    // Table-driven pixel selection.
    for (int i = 0; i < 7; i++) begin
      hcount = pv[i].h; vcount = pv[i].v;
      step();
      check($sformatf("pix%0d_rgb", i), rgb_out, pv[i].img ? 32'h0ABC : 32'h0123);
    end

    // A press during COMMIT is dropped: exactly one flip of tile 3.
    mouse_left = 1'b0; step();
    nflip_acc = 0; nrej_acc = 0;
    xpos = 12'd700; ypos = 12'd250; mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
    step();
    mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
    repeat (5) step();
    check("commit_press_face_up", face_up, 4'b1010);
    check("commit_press_flips", nflip_acc, 1);

    // Reset while HELD with the button down, button still held after reset release.
    rgb_bg = 12'h000; rgb_image = 12'hFFF; hcount = 11'd0; vcount = 11'd0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    mouse_left = 1'b0; step(); step();
    xpos = 12'd100; ypos = 12'd250; mouse_left = 1'b1;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("midheld_rst_face_up", face_up, 0);
    check("midheld_rst_rgb_out", rgb_out, 0);
    step();
    rst_n = 1'b1;
    nflip_acc = 0; nrej_acc = 0;
    repeat (3) step();
    mouse_left = 1'b0;
    repeat (5) step();
    check("held_thru_rst_face_up", face_up, 0);
    check("held_thru_rst_up_count", up_count, 0);
    check("held_thru_rst_flips", nflip_acc, 0);
    check("held_thru_rst_rejects", nrej_acc, 0);
    check("held_thru_rst_rgb_out", rgb_out, 0);
    do_click(12'd100, 12'd250, 12'd100, 12'd250, 1);
    check("after_rst_click_face_up", face_up, 4'b0001);
    check("after_rst_click_flips", nflip_acc, 1);

    // Random clicks and pixels against the reference model.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    for (int k = 0; k < 4; k++) m_fu[k] = 0;
    for (int it = 0; it < 60; it++) begin
      int px, py, rx, ry, pt, rt, cnt, efl, erj;
      logic [3:0] efu;
      px = rand_x(); py = rand_y();
      if ($urandom_range(0, 1) == 0) begin
        rx = px; ry = py;
      end else begin
        rx = rand_x(); ry = rand_y();
      end
      pt = tile_of(px, py);
      rt = tile_of(rx, ry);
      cnt = m_fu[0] + m_fu[1] + m_fu[2] + m_fu[3];
      efl = 0; erj = 0;
      if (pt >= 0 && rt == pt) begin
        if (m_fu[pt] == 1) begin
          m_fu[pt] = 0; efl = 1;
        end else if (cnt < MAXU) begin
          m_fu[pt] = 1; efl = 1;
        end else begin
          erj = 1;
        end
      end
      do_click(12'(px), 12'(py), 12'(rx), 12'(ry), int'($urandom_range(0, 3)));
      efu = {m_fu[3] != 0, m_fu[2] != 0, m_fu[1] != 0, m_fu[0] != 0};
      check($sformatf("rnd%0d_face_up", it), face_up, efu);
      check($sformatf("rnd%0d_up_count", it), up_count, m_fu[0] + m_fu[1] + m_fu[2] + m_fu[3]);
      check($sformatf("rnd%0d_flips", it), nflip_acc, efl);
      check($sformatf("rnd%0d_rejects", it), nrej_acc, erj);
      for (int p = 0; p < 3; p++) begin
        int h, v, t;
        logic [11:0] img, bg, exp_rgb;
        h = rand_x(); v = rand_y();
        img = 12'($urandom); bg = 12'($urandom);
        t = tile_of(h, v);
        exp_rgb = (t >= 0 && m_fu[t] == 1) ? img : bg;
        hcount = 11'(h); vcount = 11'(v); rgb_image = img; rgb_bg = bg;
        step();
        check($sformatf("rnd%0d_pix%0d", it, p), rgb_out, exp_rgb);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
